// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment display bank.
//   One BCD-to-segment decoder is shared by DIGITS digits: the controller walks
//   through the digits, enabling one active-low anode at a time, and puts an
//   all-dark blanking gap in front of every digit so no ghost image is seen.
//   New values are loaded into a pending register at any time and are moved to
//   the displayed (shadow) register only at a frame boundary.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = scanning, 0 = display dark
//   load         1-cycle strobe, captures digits_bcd into the pending register
//   digits_bcd   packed BCD, digit i = [4i+3:4i], digit DIGITS-1 most significant
//   lz_suppress  1 = blank leading zeros (digit 0 is always shown)
//   bcd_sel      code to the decoder, 4'hF = blank
//   an_n         active-low anode enables, at most one bit low
//   frame_done   1-cycle pulse after the last DRIVE cycle of the last digit

module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DRIVE_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic                  lz_suppress,
  output logic [3:0]            bcd_sel,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic [3:0]            bcd_sel_q, bcd_sel_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            cur_digit;
  logic                  upper_zero;
  logic                  lz_blank;
  logic [DIGITS-1:0]     drive_an;

  // Pick the shadow digit for the current index and decide whether it is a
  // leading zero (this digit and every more significant one are zero).
  always_comb begin
    cur_digit  = 4'h0;
    upper_zero = 1'b1;
    drive_an   = '1;
    for (int j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) == idx_q) begin
        cur_digit   = shadow_q[4*j +: 4];
        drive_an[j] = 1'b0;
      end
      if (j >= int'(idx_q) && shadow_q[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank = lz_suppress && (idx_q != '0) && upper_zero;
  end

  // Next-state logic. Outputs are computed here for the state being entered
  // and registered, so the anode and its code switch on the same edge, and
  // they are only ever loaded on the BLANK->DRIVE edge. The segment code is
  // therefore held for the whole DRIVE slot, which keeps a lit digit from
  // ever showing another code; lz_suppress is taken on that same edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pending_d    = load ? digits_bcd : pending_q;
    shadow_d     = shadow_q;
    an_n_d       = an_n_q;
    bcd_sel_d    = bcd_sel_q;
    frame_done_d = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      an_n_d    = '1;
      bcd_sel_d = BLANK_CODE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_BLANK;
          idx_d     = '0;
          cnt_d     = '0;
          shadow_d  = pending_d;
          an_n_d    = '1;
          bcd_sel_d = BLANK_CODE;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d   = ST_DRIVE;
            cnt_d     = '0;
            an_n_d    = drive_an;
            bcd_sel_d = lz_blank ? BLANK_CODE : cur_digit;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d   = ST_BLANK;
            cnt_d     = '0;
            an_n_d    = '1;
            bcd_sel_d = BLANK_CODE;
            if (idx_q == IDX_LAST) begin
              // Frame boundary: the only place the displayed value changes.
              idx_d        = '0;
              frame_done_d = 1'b1;
              shadow_d     = pending_d;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          an_n_d    = '1;
          bcd_sel_d = BLANK_CODE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset to a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      an_n_q       <= '1;
      bcd_sel_q    <= BLANK_CODE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      an_n_q       <= an_n_d;
      bcd_sel_q    <= bcd_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign bcd_sel    = bcd_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Bench for display_scan_ctrl with DIGITS=4, DRIVE_CYCLES=4, BLANK_CYCLES=2.
//   A behavioural model describes the scan as a position within the frame
//   (cycles since scanning started, modulo the frame period) and is compared
//   against the DUT on every falling edge. Hand-computed checkpoints pin the
//   model to known values.

module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DRIVE  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = DRIVE + BLANK;
  localparam int FRAME  = DIGITS * SLOT;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic                load;
  logic [4*DIGITS-1:0] digits_bcd;
  logic                lz_suppress;
  logic [3:0]          bcd_sel;
  logic [DIGITS-1:0]   an_n;
  logic                frame_done;

  int errors = 0;
  int checks = 0;

  display_scan_ctrl #(
    .DIGITS      (DIGITS),
    .DRIVE_CYCLES(DRIVE),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .digits_bcd (digits_bcd),
    .lz_suppress(lz_suppress),
    .bcd_sel    (bcd_sel),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: scanning position is a plain cycle count since the
  // enabling edge; digit, blank/drive and frame boundary follow by division.
  bit                  m_running = 0;
  int                  m_phase   = 0;
  logic [4*DIGITS-1:0] m_pending = '0;
  logic [4*DIGITS-1:0] m_shadow  = '0;
  bit                  m_lz      = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [4*DIGITS-1:0] new_pending;
    if (!rst_n) begin
      m_running = 0;
      m_phase   = 0;
      m_pending = '0;
      m_shadow  = '0;
      m_lz      = 0;
    end else begin
      new_pending = load ? digits_bcd : m_pending;
      if (!enable) begin
        m_running = 0;
        m_phase   = 0;
      end else if (!m_running) begin
        m_running = 1;
        m_phase   = 0;
        m_shadow  = new_pending;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase % FRAME == 0) m_shadow = new_pending;
        if (m_phase % SLOT == BLANK) m_lz = lz_suppress;
      end
      m_pending = new_pending;
    end
  end

  // Expected outputs from the model state.
  task automatic modelOutputs(output logic [DIGITS-1:0] exp_an,
                              output logic [3:0] exp_bcd,
                              output logic exp_fd);
    int p, d, w;
    logic [4*DIGITS-1:0] upper;
    exp_an  = '1;
    exp_bcd = 4'hF;
    exp_fd  = 1'b0;
    if (m_running) begin
      p = m_phase % FRAME;
      d = p / SLOT;
      w = p % SLOT;
      exp_fd = (p == 0) && (m_phase > 0);
      if (w >= BLANK) begin
        exp_an    = '1;
        exp_an[d] = 1'b0;
        upper     = m_shadow >> (4 * d);
        if (m_lz && d > 0 && upper == '0) exp_bcd = 4'hF;
        else exp_bcd = m_shadow[4*d +: 4];
      end
    end
  endtask

  // Per-cycle compare against the model plus the ordering invariants.
  logic [DIGITS-1:0] prev_an  = '1;
  logic [3:0]        prev_bcd = 4'hF;

  always @(negedge clk) begin
    logic [DIGITS-1:0] exp_an;
    logic [3:0]        exp_bcd;
    logic              exp_fd;
    int                lows;
    modelOutputs(exp_an, exp_bcd, exp_fd);
    checks++;
    if (an_n !== exp_an || bcd_sel !== exp_bcd || frame_done !== exp_fd) begin
      errors++;
      $display("[TB] FAIL model t=%0t phase=%0d: an_n=%b bcd_sel=%h frame_done=%b, expected an_n=%b bcd_sel=%h frame_done=%b",
               $time, m_phase, an_n, bcd_sel, frame_done, exp_an, exp_bcd, exp_fd);
    end
    lows = 0;
    for (int i = 0; i < DIGITS; i++) if (an_n[i] === 1'b0) lows++;
    checks++;
    if (lows > 1) begin
      errors++;
      $display("[TB] FAIL one_hot t=%0t: an_n=%b has %0d low bits, expected at most 1", $time, an_n, lows);
    end
    checks++;
    if (prev_an != '1 && an_n != '1 && bcd_sel !== prev_bcd) begin
      errors++;
      $display("[TB] FAIL bcd_stable t=%0t: bcd_sel=%h changed from %h while an_n=%b", $time, bcd_sel, prev_bcd, an_n);
    end
    prev_an  = an_n;
    prev_bcd = bcd_sel;
  end

  // Literal checkpoint against hand-computed values.
  task automatic checkOutput(input string name, input logic [DIGITS-1:0] exp_an,
                             input logic [3:0] exp_bcd, input logic exp_fd);
    checks++;
    if (an_n !== exp_an || bcd_sel !== exp_bcd || frame_done !== exp_fd) begin
      errors++;
      $display("[TB] FAIL %s: an_n=%b bcd_sel=%h frame_done=%b, expected an_n=%b bcd_sel=%h frame_done=%b",
               name, an_n, bcd_sel, frame_done, exp_an, exp_bcd, exp_fd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle load strobe, driven from a falling edge.
  task automatic applyStimulus(input logic [4*DIGITS-1:0] value);
    load       = 1'b1;
    digits_bcd = value;
    tick(1);
    load       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    load        = 1'b0;
    digits_bcd  = '0;
    lz_suppress = 1'b0;

    // Reset, then hold disabled.
    tick(2);
    checkOutput("reset", 4'b1111, 4'hF, 1'b0);
    rst_n = 1'b1;
    tick(20);
    checkOutput("idle_dark", 4'b1111, 4'hF, 1'b0);

    // Load 1234 and scan one frame; phase numbers count from the enabling edge.
    applyStimulus(16'h1234);
    enable = 1'b1;
    tick(1);  checkOutput("f1_blank0",  4'b1111, 4'hF, 1'b0);   // phase 0
    tick(2);  checkOutput("f1_digit0",  4'b1110, 4'h4, 1'b0);   // phase 2
    tick(6);  checkOutput("f1_digit1",  4'b1101, 4'h3, 1'b0);   // phase 8
    tick(6);  checkOutput("f1_digit2",  4'b1011, 4'h2, 1'b0);   // phase 14
    tick(6);  checkOutput("f1_digit3",  4'b0111, 4'h1, 1'b0);   // phase 20
    tick(4);  checkOutput("f1_done",    4'b1111, 4'hF, 1'b1);   // phase 24
    tick(1);  checkOutput("f2_no_done", 4'b1111, 4'hF, 1'b0);   // phase 25

    // Mid-frame load of 0007 with suppression: current frame keeps 1234.
    lz_suppress = 1'b1;
    applyStimulus(16'h0007);                                    // now phase 26
    checkOutput("f2_digit0_old", 4'b1110, 4'h4, 1'b0);
    tick(6);  checkOutput("f2_digit1_old", 4'b1101, 4'h3, 1'b0); // phase 32
    tick(16); checkOutput("f3_done",       4'b1111, 4'hF, 1'b1); // phase 48
    tick(2);  checkOutput("f3_digit0",     4'b1110, 4'h7, 1'b0); // phase 50
    tick(6);  checkOutput("f3_digit1_lz",  4'b1101, 4'hF, 1'b0); // phase 56
    tick(6);  checkOutput("f3_digit2_lz",  4'b1011, 4'hF, 1'b0); // phase 62
    tick(6);  checkOutput("f3_digit3_lz",  4'b0111, 4'hF, 1'b0); // phase 68

    // All zeros: suppressed shows only digit 0, unsuppressed shows all.
    tick(1);
    applyStimulus(16'h0000);                                    // now phase 70
    tick(4);  checkOutput("f4_digit0_zero", 4'b1110, 4'h0, 1'b0); // phase 74
    tick(6);  checkOutput("f4_digit1_lz",   4'b1101, 4'hF, 1'b0); // phase 80
    tick(4);  lz_suppress = 1'b0;                                // phase 84, blank
    tick(14); checkOutput("f5_digit0_zero", 4'b1110, 4'h0, 1'b0); // phase 98
    tick(6);  checkOutput("f5_digit1_zero", 4'b1101, 4'h0, 1'b0); // phase 104
    tick(6);  checkOutput("f5_digit2_zero", 4'b1011, 4'h0, 1'b0); // phase 110
    tick(6);  checkOutput("f5_digit3_zero", 4'b0111, 4'h0, 1'b0); // phase 116

    // Drop enable while digit 2 is driven, then restart from digit 0.
    tick(18); checkOutput("f6_digit2", 4'b1011, 4'h0, 1'b0);    // phase 134
    enable = 1'b0;
    tick(1);  checkOutput("disable_dark",  4'b1111, 4'hF, 1'b0);
    tick(3);  checkOutput("disable_stays", 4'b1111, 4'hF, 1'b0);
    enable = 1'b1;
    tick(1);  checkOutput("restart_blank",  4'b1111, 4'hF, 1'b0);
    tick(2);  checkOutput("restart_digit0", 4'b1110, 4'h0, 1'b0);

    // Asynchronous reset between edges during a DRIVE slot.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'b1111, 4'hF, 1'b0);
    tick(2);
    checkOutput("reset_held", 4'b1111, 4'hF, 1'b0);
    rst_n = 1'b1;
    tick(1);  checkOutput("post_reset_blank",  4'b1111, 4'hF, 1'b0);
    tick(2);  checkOutput("post_reset_digit0", 4'b1110, 4'h0, 1'b0);
    tick(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
